// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//     - BCD_DIG_W : width of one BCD digit
//     - state_e   : converter FSM encoding (ST_IDLE, ST_SHIFT)
//     - bcd_digits: number of decimal digits needed for a w-bit unsigned value,
//                   ceil(w * log10(2)), used for default sizing
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_DIG_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // log10(2) ~= 0.30103; the +99999 turns the integer division into a ceiling.
    function automatic int bcd_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// -----------------------------------------------------------------------------
// bcd_dabble_digit
//   Combinational double-dabble correction cell for one BCD digit:
//   a digit of 5 or more gets +3 so that the following left shift carries
//   correctly into the next decimal digit. 4-bit arithmetic, no carry out.
//
// Ports
//   din   in   BCD_DIG_W   working digit before correction
//   dout  out  BCD_DIG_W   corrected digit
// -----------------------------------------------------------------------------
module bcd_dabble_digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIG_W-1:0] din,
    output logic [BCD_DIG_W-1:0] dout
);

    always_comb begin
        dout = (din >= BCD_DIG_W'(5)) ? din + BCD_DIG_W'(3) : din;
    end

endmodule

// File: rtl/bin_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3). A conversion takes
//   BIN_W shift cycles; the published result (bcd/ovf/blank) holds its previous
//   value throughout and updates together with the one-cycle done pulse.
//
// Parameters
//   BIN_W   width of the unsigned operand (1..32)
//   DIGITS  number of BCD digits produced (default: enough for BIN_W bits)
//
// Ports
//   clk     in   1              rising-edge clock
//   rst     in   1              synchronous reset, active-high
//   start   in   1              conversion request, sampled only while idle
//   bin     in   BIN_W          operand, captured on the accepting edge
//   busy    out  1              conversion in progress
//   done    out  1              one-cycle pulse, result outputs just updated
//   bcd     out  4*DIGITS       result, digit 0 (units) in bcd[3:0]
//   ovf     out  1              value did not fit (bcd = value mod 10^DIGITS)
//   blank   out  DIGITS         leading-zero mask, blank[0] always 0
// -----------------------------------------------------------------------------
module bin_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = bcd_digits(BIN_W)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIG_W*DIGITS-1:0]   bcd,
    output logic                          ovf,
    output logic [DIGITS-1:0]             blank
);

    localparam int BCD_W = BCD_DIG_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int VEC_W = BCD_W + BIN_W;

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BIN_W);
    // All digits above the units digit blank; the units digit is always shown.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [BIN_W-1:0]    opnd_q,     opnd_d;
    logic [BCD_W-1:0]    work_q,     work_d;
    logic                ovf_work_q, ovf_work_d;
    logic [BCD_W-1:0]    bcd_q,      bcd_d;
    logic                ovf_q,      ovf_d;
    logic [DIGITS-1:0]   blank_q,    blank_d;
    logic                done_q,     done_d;

    logic [BCD_W-1:0]    adj;
    logic [VEC_W-1:0]    shifted;

    // Add-3 correction of every working digit, ahead of this cycle's shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_dabble_digit u_digit (
            .din  (work_q[g*BCD_DIG_W +: BCD_DIG_W]),
            .dout (adj[g*BCD_DIG_W +: BCD_DIG_W])
        );
    end

    // The whole {digits, operand} vector moves left one bit; the operand MSB
    // enters the units digit and the top digit's MSB falls off the end.
    always_comb begin
        shifted = {adj, opnd_q} << 1;
    end

    // blank[i] is set when digit i and every digit above it are zero.
    function automatic logic [DIGITS-1:0] leading_blank(input logic [BCD_W-1:0] d);
        logic [DIGITS-1:0] b;
        logic              all_zero;
        b        = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (d[i*BCD_DIG_W +: BCD_DIG_W] == '0);
            b[i]     = all_zero;
        end
        return b;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        work_d     = work_q;
        ovf_work_d = ovf_work_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        blank_d    = blank_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SHIFT;
                    opnd_d     = bin;
                    work_d     = '0;
                    ovf_work_d = 1'b0;
                    cnt_d      = CNT_LOAD;
                end
            end

            ST_SHIFT: begin
                work_d     = shifted[VEC_W-1:BIN_W];
                opnd_d     = shifted[BIN_W-1:0];
                // Sticky: any 1 lost off the top digit means the value wrapped.
                ovf_work_d = ovf_work_q | adj[BCD_W-1];
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    bcd_d   = work_d;
                    ovf_d   = ovf_work_d;
                    blank_d = leading_blank(work_d);
                    done_d  = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            opnd_q     <= '0;
            work_q     <= '0;
            ovf_work_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            blank_q    <= BLANK_RST;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            work_q     <= work_d;
            ovf_work_q <= ovf_work_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            blank_q    <= blank_d;
            done_q     <= done_d;
        end
    end

    assign busy  = (state_q == ST_SHIFT);
    assign done  = done_q;
    assign bcd   = bcd_q;
    assign ovf   = ovf_q;
    assign blank = blank_q;

endmodule
